// File: rtl/pipe_pkg.sv
// Shared pipeline-register package: default field widths, payload layout helpers
// and the skid-buffer state encoding used by the IF/ID, ID/EX and EX/MEM stages.
package pipe_pkg;

  localparam int WB_W_DEF   = 2;
  localparam int M_W_DEF    = 3;
  localparam int EX_W_DEF   = 4;
  localparam int REG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;

  // Bit 1 is the skid-occupied flag so the registered ready is a plain flop bit.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } skid_state_e;

  // Payload layout, LSB first: RegRd, RegRt, RegRs, Immediate, Data2, Data1, EX, M, WB
  function automatic int payload_w(int wb_w, int m_w, int ex_w, int data_w, int reg_w);
    return wb_w + m_w + ex_w + 3 * data_w + 3 * reg_w;
  endfunction

  function automatic int off_rt(int reg_w);
    return reg_w;
  endfunction

  function automatic int off_rs(int reg_w);
    return 2 * reg_w;
  endfunction

  function automatic int off_imm(int reg_w);
    return 3 * reg_w;
  endfunction

  function automatic int off_data2(int data_w, int reg_w);
    return 3 * reg_w + data_w;
  endfunction

  function automatic int off_data1(int data_w, int reg_w);
    return 3 * reg_w + 2 * data_w;
  endfunction

  function automatic int off_ex(int data_w, int reg_w);
    return 3 * reg_w + 3 * data_w;
  endfunction

  function automatic int off_m(int ex_w, int data_w, int reg_w);
    return off_ex(data_w, reg_w) + ex_w;
  endfunction

  function automatic int off_wb(int m_w, int ex_w, int data_w, int reg_w);
    return off_m(ex_w, data_w, reg_w) + m_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bus: upstream beat, downstream beat, handshake and flush.
// slave = the pipeline register, master = the decode/execute side driving it.
interface id_ex_pipe_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int EX_W   = EX_W_DEF
) ();

  logic              Flush_i;
  logic              Valid_i;
  logic              Ready_o;
  logic [WB_W-1:0]   WB_i;
  logic [M_W-1:0]    M_i;
  logic [EX_W-1:0]   EX_i;
  logic [DATA_W-1:0] Data1_i;
  logic [DATA_W-1:0] Data2_i;
  logic [DATA_W-1:0] Immediate_i;
  logic [REG_W-1:0]  RegRs_i;
  logic [REG_W-1:0]  RegRt_i;
  logic [REG_W-1:0]  RegRd_i;

  logic              Valid_o;
  logic              Ready_i;
  logic [WB_W-1:0]   WB_o;
  logic [M_W-1:0]    M_o;
  logic [EX_W-1:0]   EX_o;
  logic [DATA_W-1:0] Data1_o;
  logic [DATA_W-1:0] Data2_o;
  logic [DATA_W-1:0] Immediate_o;
  logic [REG_W-1:0]  RegRs_o;
  logic [REG_W-1:0]  RegRt_o;
  logic [REG_W-1:0]  RegRd_o;

  modport slave (
    input  Flush_i, Valid_i, WB_i, M_i, EX_i, Data1_i, Data2_i, Immediate_i,
           RegRs_i, RegRt_i, RegRd_i, Ready_i,
    output Ready_o, Valid_o, WB_o, M_o, EX_o, Data1_o, Data2_o, Immediate_o,
           RegRs_o, RegRt_o, RegRd_o
  );

  modport master (
    output Flush_i, Valid_i, WB_i, M_i, EX_i, Data1_i, Data2_i, Immediate_i,
           RegRs_i, RegRt_i, RegRd_i, Ready_i,
    input  Ready_o, Valid_o, WB_o, M_o, EX_o, Data1_o, Data2_o, Immediate_o,
           RegRs_o, RegRt_o, RegRd_o
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional skid entry and sync flush.
// ID_EX_SKID_EN defined: two entries, Ready_o from a flop; undefined: one entry, combinational ready.
//
// state   | meaning
// S_EMPTY | output register empty, skid empty
// S_ONE   | output register holds a beat, skid empty
// S_TWO   | output register stalled, skid holds the next beat
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 Clock_i,
  input  logic                 Reset_i,
  input  logic                 Flush_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] out_q, skid_q;
  logic                 load_out, load_skid, sel_skid;

`ifdef ID_EX_SKID_EN
  assign in_ready = ~state_q[1];
`else
  assign in_ready = out_ready || (state_q == S_EMPTY);
`endif

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = out_q;

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  // In every branch that loads from in_data, in_ready is already 1.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    if (Flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_valid) begin
            load_out = 1'b1;
            state_d  = S_ONE;
          end
        end
        S_ONE: begin
          if (out_ready) begin
            if (in_valid) load_out = 1'b1;
            else          state_d  = S_EMPTY;
          end else if (in_valid) begin
`ifdef ID_EX_SKID_EN
            load_skid = 1'b1;
            state_d   = S_TWO;
`endif
          end
        end
        S_TWO: begin
          if (out_ready) begin
            load_out = 1'b1;
            sel_skid = 1'b1;
            state_d  = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= sel_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: packs the decode beat, hands it to pipe_skid_buf and
// masks WB/M/EX to zero on bubbles. Skid entry enabled by defining ID_EX_SKID_EN.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int EX_W   = EX_W_DEF
) (
  input  logic               Clock_i,
  input  logic               Reset_i,
  id_ex_pipe_reg_if.slave    bus
);

  localparam int PW        = payload_w(WB_W, M_W, EX_W, DATA_W, REG_W);
  localparam int OFF_RD    = 0;
  localparam int OFF_RT    = off_rt(REG_W);
  localparam int OFF_RS    = off_rs(REG_W);
  localparam int OFF_IMM   = off_imm(REG_W);
  localparam int OFF_DATA2 = off_data2(DATA_W, REG_W);
  localparam int OFF_DATA1 = off_data1(DATA_W, REG_W);
  localparam int OFF_EX    = off_ex(DATA_W, REG_W);
  localparam int OFF_M     = off_m(EX_W, DATA_W, REG_W);
  localparam int OFF_WB    = off_wb(M_W, EX_W, DATA_W, REG_W);

  logic [PW-1:0] in_pl, out_pl;
  logic          out_valid;

  assign in_pl = {bus.WB_i, bus.M_i, bus.EX_i, bus.Data1_i, bus.Data2_i,
                  bus.Immediate_i, bus.RegRs_i, bus.RegRt_i, bus.RegRd_i};

  pipe_skid_buf #(
    .PAYLOAD_W (PW)
  ) u_skid (
    .Clock_i   (Clock_i),
    .Reset_i   (Reset_i),
    .Flush_i   (bus.Flush_i),
    .in_valid  (bus.Valid_i),
    .in_ready  (bus.Ready_o),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (bus.Ready_i),
    .out_data  (out_pl)
  );

  assign bus.Valid_o = out_valid;

  // Control groups are forced to zero on a bubble; data/address are left as don't-care.
  assign bus.WB_o = out_valid ? out_pl[OFF_WB +: WB_W] : '0;
  assign bus.M_o  = out_valid ? out_pl[OFF_M  +: M_W]  : '0;
  assign bus.EX_o = out_valid ? out_pl[OFF_EX +: EX_W] : '0;

  assign bus.Data1_o     = out_pl[OFF_DATA1 +: DATA_W];
  assign bus.Data2_o     = out_pl[OFF_DATA2 +: DATA_W];
  assign bus.Immediate_o = out_pl[OFF_IMM   +: DATA_W];
  assign bus.RegRs_o     = out_pl[OFF_RS    +: REG_W];
  assign bus.RegRt_o     = out_pl[OFF_RT    +: REG_W];
  assign bus.RegRd_o     = out_pl[OFF_RD    +: REG_W];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; expectations follow whichever build
// (ID_EX_SKID_EN defined or not) it is compiled with.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  id_ex_pipe_reg_if bus ();

  id_ex_pipe_reg dut (
    .Clock_i (clk),
    .Reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic v, input logic [1:0] wb, input logic [2:0] m,
                          input logic [3:0] ex, input logic [31:0] d1);
    bus.Valid_i     = v;
    bus.WB_i        = wb;
    bus.M_i         = m;
    bus.EX_i        = ex;
    bus.Data1_i     = d1;
    bus.Data2_i     = ~d1;
    bus.Immediate_i = d1 ^ 32'h5A5A_0000;
    bus.RegRs_i     = 5'd3;
    bus.RegRt_i     = 5'd17;
    bus.RegRd_i     = d1[4:0] ^ 5'h1F;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.Flush_i = 1'b0;
    bus.Ready_i = 1'b0;
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    #3;
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.Valid_o); end
    checks++; if (bus.Ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.Ready_o); end
    checks++; if (bus.Data1_o !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h want 0", bus.Data1_o); end
    #9 rst = 1'b0;
    checks++; if (bus.Ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.Ready_o); end
  endtask

  task automatic test_streaming();
    tick();
    bus.Ready_i = 1'b1;
    set_beat(1'b1, 2'b01, 3'b010, 4'h1, 32'h11);
    tick();
    checks++; if (bus.Valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid0: got %b want 1", bus.Valid_o); end
    checks++; if (bus.Data1_o !== 32'h11) begin errors++; $display("FAIL stream_d0: got %h want 11", bus.Data1_o); end
    checks++; if (bus.M_o !== 3'b010) begin errors++; $display("FAIL stream_m0: got %b want 010", bus.M_o); end
    set_beat(1'b1, 2'b10, 3'b001, 4'h2, 32'h22);
    tick();
    checks++; if (bus.Valid_o !== 1'b1 || bus.Data1_o !== 32'h22) begin errors++; $display("FAIL stream_d1: got v=%b %h want v=1 22", bus.Valid_o, bus.Data1_o); end
    set_beat(1'b1, 2'b11, 3'b100, 4'h3, 32'h33);
    tick();
    checks++; if (bus.Valid_o !== 1'b1 || bus.Data1_o !== 32'h33) begin errors++; $display("FAIL stream_d2: got v=%b %h want v=1 33", bus.Valid_o, bus.Data1_o); end
    checks++; if (bus.EX_o !== 4'h3) begin errors++; $display("FAIL stream_ex2: got %h want 3", bus.EX_o); end
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    tick();
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", bus.Valid_o); end
  endtask

  task automatic test_bubble();
    bus.Ready_i = 1'b1;
    set_beat(1'b0, 2'b11, 3'b111, 4'hF, 32'hDEAD);
    tick();
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", bus.Valid_o); end
    checks++; if (bus.WB_o !== 2'b00) begin errors++; $display("FAIL bubble_wb: got %b want 00", bus.WB_o); end
    checks++; if (bus.M_o !== 3'b000 || bus.EX_o !== 4'h0) begin errors++; $display("FAIL bubble_m_ex: got %b %h want 000 0", bus.M_o, bus.EX_o); end
  endtask

  task automatic test_stall();
    logic exp_rdy;
    bus.Ready_i = 1'b0;
    set_beat(1'b1, 2'b01, 3'b001, 4'hA, 32'hA0);
    tick();
    checks++; if (bus.Valid_o !== 1'b1 || bus.EX_o !== 4'hA) begin errors++; $display("FAIL stall_a_out: got v=%b ex=%h want v=1 ex=a", bus.Valid_o, bus.EX_o); end
    set_beat(1'b1, 2'b10, 3'b110, 4'h5, 32'hB0);
`ifdef ID_EX_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    checks++; if (bus.Ready_o !== exp_rdy) begin errors++; $display("FAIL stall_ready_same: got %b want %b", bus.Ready_o, exp_rdy); end
    tick();
    checks++; if (bus.Ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready_next: got %b want 0", bus.Ready_o); end
    checks++; if (bus.EX_o !== 4'hA || bus.Data1_o !== 32'hA0 || bus.WB_o !== 2'b01) begin errors++; $display("FAIL stall_hold: got ex=%h d1=%h wb=%b want a a0 01", bus.EX_o, bus.Data1_o, bus.WB_o); end
    checks++; if (bus.Data2_o !== ~32'hA0 || bus.RegRd_o !== 5'h1F) begin errors++; $display("FAIL stall_hold_data: got %h %h want %h 1f", bus.Data2_o, bus.RegRd_o, ~32'hA0); end
`ifdef ID_EX_SKID_EN
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
`endif
    bus.Ready_i = 1'b1;
    tick();
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    checks++; if (bus.Valid_o !== 1'b1 || bus.EX_o !== 4'h5 || bus.Data1_o !== 32'hB0) begin errors++; $display("FAIL stall_release_b: got v=%b ex=%h d1=%h want 1 5 b0", bus.Valid_o, bus.EX_o, bus.Data1_o); end
    checks++; if (bus.Ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.Ready_o); end
    tick();
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus.Valid_o); end
  endtask

  task automatic test_flush();
    bus.Ready_i = 1'b0;
    set_beat(1'b1, 2'b11, 3'b011, 4'h3, 32'hC0);
    tick();
    set_beat(1'b1, 2'b10, 3'b101, 4'h7, 32'hD0);
    tick();
    bus.Flush_i = 1'b1;
    set_beat(1'b1, 2'b01, 3'b111, 4'hE, 32'hE0);
    tick();
    bus.Flush_i = 1'b0;
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.Valid_o); end
    checks++; if (bus.WB_o !== 2'b00 || bus.M_o !== 3'b000 || bus.EX_o !== 4'h0) begin errors++; $display("FAIL flush_ctrl: got %b %b %h want 0 0 0", bus.WB_o, bus.M_o, bus.EX_o); end
    checks++; if (bus.Ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.Ready_o); end
    bus.Ready_i = 1'b1;
    tick();
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_beat: got v=%b d1=%h want v=0", bus.Valid_o, bus.Data1_o); end
  endtask

  task automatic test_reset_midstall();
    bus.Ready_i = 1'b0;
    set_beat(1'b1, 2'b10, 3'b101, 4'h9, 32'hF0);
    tick();
    set_beat(1'b1, 2'b01, 3'b010, 4'h6, 32'h60);
    tick();
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    checks++; if (bus.Valid_o !== 1'b1 || bus.Data1_o !== 32'hF0) begin errors++; $display("FAIL midstall_pre: got v=%b d1=%h want 1 f0", bus.Valid_o, bus.Data1_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.Valid_o !== 1'b0 || bus.Ready_o !== 1'b1) begin errors++; $display("FAIL midstall_rst_hs: got v=%b r=%b want 0 1", bus.Valid_o, bus.Ready_o); end
    checks++; if (bus.Data1_o !== 32'h0 || bus.Data2_o !== 32'h0 || bus.Immediate_o !== 32'h0) begin errors++; $display("FAIL midstall_rst_data: got %h %h %h want 0", bus.Data1_o, bus.Data2_o, bus.Immediate_o); end
    checks++; if (bus.RegRs_o !== 5'h0 || bus.RegRt_o !== 5'h0 || bus.RegRd_o !== 5'h0 || bus.WB_o !== 2'b00) begin errors++; $display("FAIL midstall_rst_regs: got %h %h %h %b want 0", bus.RegRs_o, bus.RegRt_o, bus.RegRd_o, bus.WB_o); end
    #3 rst = 1'b0;
    bus.Ready_i = 1'b1;
    tick();
    checks++; if (bus.Valid_o !== 1'b0) begin errors++; $display("FAIL midstall_discard: got v=%b d1=%h want v=0", bus.Valid_o, bus.Data1_o); end
  endtask

  task automatic test_back_to_back();
    bus.Ready_i = 1'b1;
    set_beat(1'b1, 2'b01, 3'b100, 4'hC, 32'h1234_5678);
    tick();
    set_beat(1'b1, 2'b10, 3'b011, 4'h4, 32'h0000_0ABC);
    checks++; if (bus.Data1_o !== 32'h1234_5678 || bus.EX_o !== 4'hC) begin errors++; $display("FAIL b2b_first: got %h %h want 12345678 c", bus.Data1_o, bus.EX_o); end
    tick();
    set_beat(1'b0, 2'b00, 3'b000, 4'h0, 32'h0);
    checks++; if (bus.Valid_o !== 1'b1 || bus.WB_o !== 2'b10 || bus.M_o !== 3'b011 || bus.EX_o !== 4'h4) begin errors++; $display("FAIL b2b_ctrl: got v=%b %b %b %h want 1 10 011 4", bus.Valid_o, bus.WB_o, bus.M_o, bus.EX_o); end
    checks++; if (bus.Data2_o !== 32'hFFFF_F543 || bus.Immediate_o !== 32'h5A5A_0ABC) begin errors++; $display("FAIL b2b_data: got %h %h want fffff543 5a5a0abc", bus.Data2_o, bus.Immediate_o); end
    checks++; if (bus.RegRs_o !== 5'd3 || bus.RegRt_o !== 5'd17 || bus.RegRd_o !== 5'h03) begin errors++; $display("FAIL b2b_regs: got %h %h %h want 03 11 03", bus.RegRs_o, bus.RegRt_o, bus.RegRd_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_bubble();
    test_stall();
    test_flush();
    test_reset_midstall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
